// File: rtl/ats21_cmd_driver_if.sv
// Signal bundle between the ATS21 command driver, its upstream controller and the ATS21 block.
// The driver uses the master view; the controller/ATS21 side uses the slave view.
interface ats21_cmd_driver_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        req;
    logic        ready;
    logic [15:0] ctrlA;
    logic [15:0] ctrlB;
    logic [1:0]  statA;
    logic [1:0]  statB;
    logic        rsp_valid;
    logic [1:0]  rsp_statA;
    logic [1:0]  rsp_statB;
    logic        rsp_timeout;
    logic        busy;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, ready, statA, statB,
        output cmd_ready, req, ctrlA, ctrlB, rsp_valid, rsp_statA, rsp_statB, rsp_timeout, busy
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, ready, statA, statB,
        input  cmd_ready, req, ctrlA, ctrlB, rsp_valid, rsp_statA, rsp_statB, rsp_timeout, busy
    );
endinterface

// File: rtl/ats21_cmd_driver.sv
// Host-side ATS21 command issuer: buffers 32-bit A/B command pairs, sends each as two
// 16-bit halves over the req/ready handshake and returns one status response per pair.
module ats21_cmd_driver #(
    parameter int CMD_DEPTH     = 4,
    parameter int READY_TIMEOUT = 15,
    parameter int RESP_LAT      = 2
) (
    input logic                clk,
    input logic                reset,
    ats21_cmd_driver_if.master bus
);
    localparam int PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CW = $clog2(CMD_DEPTH + 1);
    localparam int TW = (READY_TIMEOUT > 1) ? $clog2(READY_TIMEOUT) : 1;
    localparam int LW = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(CMD_DEPTH);
    localparam logic [TW-1:0] TCNT_LAST = TW'(READY_TIMEOUT - 1);
    localparam logic [LW-1:0] LCNT_LAST = LW'(RESP_LAT - 1);
    localparam logic [1:0]    STAT_NACK = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_LO   = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [63:0]     mem_r [CMD_DEPTH];
    logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]   count_r, count_s;
    logic            cmd_ready_r;
    logic            push_s, pop_s;
    logic [63:0]     head_s;

    logic [15:0]     work_lo_a_r, work_lo_a_s;
    logic [15:0]     work_lo_b_r, work_lo_b_s;
    logic [TW-1:0]   tcnt_r, tcnt_s;
    logic [LW-1:0]   lcnt_r, lcnt_s;
    logic            req_r, req_s;
    logic [15:0]     ctrl_a_r, ctrl_a_s;
    logic [15:0]     ctrl_b_r, ctrl_b_s;
    logic            rsp_valid_r, rsp_valid_s;
    logic [1:0]      rsp_stat_a_r, rsp_stat_a_s;
    logic [1:0]      rsp_stat_b_r, rsp_stat_b_s;
    logic            rsp_timeout_r, rsp_timeout_s;
    logic            busy_r, busy_s;

    assign push_s = bus.cmd_valid && cmd_ready_r;
    assign pop_s  = (state_r == ST_IDLE) && (count_r != CW'(0));
    assign head_s = mem_r[rd_ptr_r];

    // FIFO occupancy update; simultaneous push and pop cancel out
    always_comb begin
        count_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CW'(1);
            2'b01:   count_s = count_r - CW'(1);
            default: count_s = count_r;
        endcase
    end

    // FIFO storage, pointers and registered not-full flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CMD_DEPTH; i++) begin
                mem_r[i] <= 64'h0;
            end
            wr_ptr_r    <= PW'(0);
            rd_ptr_r    <= PW'(0);
            count_r     <= CW'(0);
            cmd_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {bus.cmd_a, bus.cmd_b};
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r     <= count_s;
            cmd_ready_r <= (count_s != FULL_CNT);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (count_r != CW'(0)) state_s = ST_REQ;
                else                   state_s = ST_IDLE;
            end
            ST_REQ: begin
                if (bus.ready)                  state_s = ST_LO;
                else if (tcnt_r == TCNT_LAST)   state_s = ST_IDLE;
                else                            state_s = ST_REQ;
            end
            ST_LO:   state_s = ST_WAIT;
            ST_WAIT: begin
                if (lcnt_r == LCNT_LAST) state_s = ST_IDLE;
                else                     state_s = ST_WAIT;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, counters and working halves
    always_comb begin
        work_lo_a_s   = work_lo_a_r;
        work_lo_b_s   = work_lo_b_r;
        tcnt_s        = tcnt_r;
        lcnt_s        = lcnt_r;
        req_s         = req_r;
        ctrl_a_s      = ctrl_a_r;
        ctrl_b_s      = ctrl_b_r;
        rsp_valid_s   = 1'b0;
        rsp_stat_a_s  = rsp_stat_a_r;
        rsp_stat_b_s  = rsp_stat_b_r;
        rsp_timeout_s = rsp_timeout_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    work_lo_a_s = head_s[47:32];
                    work_lo_b_s = head_s[15:0];
                    req_s       = 1'b1;
                    ctrl_a_s    = head_s[63:48];
                    ctrl_b_s    = head_s[31:16];
                    tcnt_s      = TW'(0);
                end else begin
                    req_s    = 1'b0;
                    ctrl_a_s = 16'h0000;
                    ctrl_b_s = 16'h0000;
                end
            end
            ST_REQ: begin
                if (bus.ready) begin
                    req_s    = 1'b0;
                    ctrl_a_s = work_lo_a_r;
                    ctrl_b_s = work_lo_b_r;
                end else if (tcnt_r == TCNT_LAST) begin
                    // Abort: ATS21 never answered, report a Nack-coded timeout
                    req_s         = 1'b0;
                    ctrl_a_s      = 16'h0000;
                    ctrl_b_s      = 16'h0000;
                    rsp_valid_s   = 1'b1;
                    rsp_timeout_s = 1'b1;
                    rsp_stat_a_s  = STAT_NACK;
                    rsp_stat_b_s  = STAT_NACK;
                end else begin
                    tcnt_s = tcnt_r + TW'(1);
                end
            end
            ST_LO: begin
                ctrl_a_s = 16'h0000;
                ctrl_b_s = 16'h0000;
                lcnt_s   = LW'(0);
            end
            ST_WAIT: begin
                if (lcnt_r == LCNT_LAST) begin
                    rsp_valid_s   = 1'b1;
                    rsp_timeout_s = 1'b0;
                    rsp_stat_a_s  = bus.statA;
                    rsp_stat_b_s  = bus.statB;
                end else begin
                    lcnt_s = lcnt_r + LW'(1);
                end
            end
            default: begin
                req_s    = 1'b0;
                ctrl_a_s = 16'h0000;
                ctrl_b_s = 16'h0000;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            work_lo_a_r   <= 16'h0000;
            work_lo_b_r   <= 16'h0000;
            tcnt_r        <= TW'(0);
            lcnt_r        <= LW'(0);
            req_r         <= 1'b0;
            ctrl_a_r      <= 16'h0000;
            ctrl_b_r      <= 16'h0000;
            rsp_valid_r   <= 1'b0;
            rsp_stat_a_r  <= STAT_NACK;
            rsp_stat_b_r  <= STAT_NACK;
            rsp_timeout_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            work_lo_a_r   <= work_lo_a_s;
            work_lo_b_r   <= work_lo_b_s;
            tcnt_r        <= tcnt_s;
            lcnt_r        <= lcnt_s;
            req_r         <= req_s;
            ctrl_a_r      <= ctrl_a_s;
            ctrl_b_r      <= ctrl_b_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_stat_a_r  <= rsp_stat_a_s;
            rsp_stat_b_r  <= rsp_stat_b_s;
            rsp_timeout_r <= rsp_timeout_s;
            busy_r        <= busy_s;
        end
    end

    assign bus.cmd_ready   = cmd_ready_r;
    assign bus.req         = req_r;
    assign bus.ctrlA       = ctrl_a_r;
    assign bus.ctrlB       = ctrl_b_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_statA   = rsp_stat_a_r;
    assign bus.rsp_statB   = rsp_stat_b_r;
    assign bus.rsp_timeout = rsp_timeout_r;
    assign bus.busy        = busy_r;
endmodule

// File: tb/tb_ats21_cmd_driver.sv
// Directed self-checking bench for ats21_cmd_driver (default parameters).
module tb_ats21_cmd_driver;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    ats21_cmd_driver_if bus();

    ats21_cmd_driver #(
        .CMD_DEPTH(4), .READY_TIMEOUT(15), .RESP_LAT(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Negedge monitor: upper halves at req rise, lower halves (ctrlA != 0 while req low), responses
    logic [15:0] up_q[$];
    logic [15:0] lo_q[$];
    int          rsp_n;
    int          to_n;
    logic        prev_req;
    initial prev_req = 1'b0;
    always @(negedge clk) begin
        if (bus.req && !prev_req) up_q.push_back(bus.ctrlA);
        if (!bus.req && bus.ctrlA != 16'h0000) lo_q.push_back(bus.ctrlA);
        if (bus.rsp_valid) begin
            rsp_n++;
            if (bus.rsp_timeout) to_n++;
        end
        prev_req = bus.req;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        up_q.delete();
        lo_q.delete();
        rsp_n = 0;
        to_n  = 0;
    endtask

    task automatic push_cmd(input logic [31:0] a, input logic [31:0] b);
        int g;
        g = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        while (!bus.cmd_ready && g < 50) begin
            step();
            g++;
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_accept: cmd_ready=%b required 1 within 50 cycles", bus.cmd_ready);
        end
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_a = 32'h0; bus.cmd_b = 32'h0;
        bus.ready = 1'b0; bus.statA = 2'b00; bus.statB = 2'b00;
        repeat (3) step();
        checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b required 0", bus.req); end
        checks++; if (bus.ctrlA !== 16'h0000) begin errors++; $display("FAIL rst_ctrlA: got %h required 0000", bus.ctrlA); end
        checks++; if (bus.ctrlB !== 16'h0000) begin errors++; $display("FAIL rst_ctrlB: got %h required 0000", bus.ctrlB); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b required 0", bus.rsp_valid); end
        checks++; if ({bus.rsp_statA, bus.rsp_statB} !== 4'b1010) begin errors++; $display("FAIL rst_rsp_stat: got %b required 1010", {bus.rsp_statA, bus.rsp_statB}); end
        checks++; if (bus.rsp_timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b required 0", bus.rsp_timeout); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", bus.busy); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b required 1", bus.cmd_ready); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_single();
        clear_mon();
        push_cmd(32'h2A40_1234, 32'h4C80_0000);
        step();
        checks++; if ({bus.req, bus.busy} !== 2'b11) begin errors++; $display("FAIL single_req_up: req,busy=%b required 11", {bus.req, bus.busy}); end
        checks++; if ({bus.ctrlA, bus.ctrlB} !== 32'h2A40_4C80) begin errors++; $display("FAIL single_upper: got %h required 2a404c80", {bus.ctrlA, bus.ctrlB}); end
        step();
        checks++; if ({bus.req, bus.ctrlA} !== 17'h1_2A40) begin errors++; $display("FAIL single_hold: got %h required 12a40", {bus.req, bus.ctrlA}); end
        bus.ready = 1'b1;
        step();
        bus.ready = 1'b0; bus.statA = 2'b00; bus.statB = 2'b01;
        checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL single_req_drop: got %b required 0", bus.req); end
        checks++; if ({bus.ctrlA, bus.ctrlB} !== 32'h1234_0000) begin errors++; $display("FAIL single_lower: got %h required 12340000", {bus.ctrlA, bus.ctrlB}); end
        step();
        checks++; if ({bus.ctrlA, bus.rsp_valid} !== 17'h0_0000) begin errors++; $display("FAIL single_ctrl_clear: got %h required 00000", {bus.ctrlA, bus.rsp_valid}); end
        step();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_rsp: got %b required 0", bus.rsp_valid); end
        step();
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b required 1", bus.rsp_valid); end
        checks++; if ({bus.rsp_statA, bus.rsp_statB, bus.rsp_timeout, bus.busy} !== 6'b0001_00) begin errors++; $display("FAIL single_rsp_fields: got %b required 000100", {bus.rsp_statA, bus.rsp_statB, bus.rsp_timeout, bus.busy}); end
        step();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_pulse: got %b required 0", bus.rsp_valid); end
    endtask

    task automatic test_timeout();
        int cnt;
        int g;
        cnt = 0; g = 0;
        bus.statA = 2'b01; bus.statB = 2'b00; bus.ready = 1'b0;
        push_cmd(32'h1111_2222, 32'h3333_4444);
        step();
        while (!bus.rsp_valid && g < 40) begin
            if (bus.req) cnt++;
            step();
            g++;
        end
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL to_rsp_valid: got %b required 1", bus.rsp_valid); end
        checks++; if (cnt != 15) begin errors++; $display("FAIL to_req_cycles: got %0d required 15", cnt); end
        checks++; if ({bus.rsp_timeout, bus.rsp_statA, bus.rsp_statB} !== 5'b1_1010) begin errors++; $display("FAIL to_rsp_fields: got %b required 11010", {bus.rsp_timeout, bus.rsp_statA, bus.rsp_statB}); end
        checks++; if ({bus.busy, bus.req, bus.ctrlA} !== 18'h0_0000) begin errors++; $display("FAIL to_idle: got %h required 00000", {bus.busy, bus.req, bus.ctrlA}); end
        step();
    endtask

    task automatic test_fifo_full();
        logic [31:0] ca [6];
        int g;
        int rsp_at_accept;
        for (int i = 0; i < 6; i++) ca[i] = {16'hA000 + 16'(i), 16'h0B00 + 16'(i)};
        bus.ready = 1'b0; bus.statA = 2'b00; bus.statB = 2'b00;
        clear_mon();
        for (int i = 0; i < 5; i++) push_cmd(ca[i], ~ca[i]);
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL full_cmd_ready: got %b required 0", bus.cmd_ready); end
        bus.cmd_valid = 1'b1; bus.cmd_a = ca[5]; bus.cmd_b = ~ca[5];
        step();
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL full_blocked: got %b required 0", bus.cmd_ready); end
        bus.ready = 1'b1;
        g = 0;
        while (!bus.cmd_ready && g < 40) begin step(); g++; end
        rsp_at_accept = rsp_n;
        checks++; if (rsp_at_accept < 1) begin errors++; $display("FAIL full_accept_after_pop: responses at accept %0d required >=1", rsp_at_accept); end
        step();
        bus.cmd_valid = 1'b0;
        g = 0;
        while (rsp_n < 6 && g < 100) begin step(); g++; end
        repeat (8) step();
        bus.ready = 1'b0;
        checks++; if (rsp_n != 6 || to_n != 0) begin errors++; $display("FAIL full_rsp_count: got %0d rsp %0d timeouts required 6 rsp 0 timeouts", rsp_n, to_n); end
        checks++; if (lo_q.size() != 6 || up_q.size() != 6) begin errors++; $display("FAIL full_halves_count: got lo %0d up %0d required 6 6", lo_q.size(), up_q.size()); end
        for (int i = 0; i < 6; i++) begin
            if (i < lo_q.size() && i < up_q.size()) begin
                checks++;
                if ({up_q[i], lo_q[i]} !== ca[i]) begin errors++; $display("FAIL full_order[%0d]: got %h required %h", i, {up_q[i], lo_q[i]}, ca[i]); end
            end
        end
    endtask

    task automatic test_push_pop_full1();
        logic [31:0] da [5];
        int g;
        for (int i = 0; i < 5; i++) da[i] = {16'hD000 + 16'(i), 16'h0E00 + 16'(i)};
        bus.ready = 1'b0;
        clear_mon();
        for (int i = 0; i < 4; i++) push_cmd(da[i], da[i]);
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL pp_full1_ready: got %b required 1", bus.cmd_ready); end
        bus.ready = 1'b1;
        g = 0;
        while (!bus.rsp_valid && g < 40) begin step(); g++; end
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL pp_rsp_wait: got %b required 1", bus.rsp_valid); end
        bus.cmd_valid = 1'b1; bus.cmd_a = da[4]; bus.cmd_b = da[4];
        step();
        bus.cmd_valid = 1'b0;
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL pp_count_same: cmd_ready=%b required 1", bus.cmd_ready); end
        step();
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL pp_ready_stays: cmd_ready=%b required 1", bus.cmd_ready); end
        g = 0;
        while (rsp_n < 5 && g < 100) begin step(); g++; end
        repeat (8) step();
        bus.ready = 1'b0;
        checks++; if (rsp_n != 5 || lo_q.size() != 5) begin errors++; $display("FAIL pp_counts: got rsp %0d lo %0d required 5 5", rsp_n, lo_q.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < lo_q.size()) begin
                checks++;
                if (lo_q[i] !== da[i][15:0]) begin errors++; $display("FAIL pp_order[%0d]: got %h required %h", i, lo_q[i], da[i][15:0]); end
            end
        end
    endtask

    task automatic test_reset_in_lo();
        bus.ready = 1'b0;
        push_cmd(32'h5A5A_C3C3, 32'h0F0F_F0F0);
        push_cmd(32'h7777_8888, 32'h9999_AAAA);
        bus.ready = 1'b1;
        step();
        bus.ready = 1'b0;
        checks++; if ({bus.req, bus.ctrlA, bus.ctrlB} !== 33'h0_C3C3_F0F0) begin errors++; $display("FAIL lo_enter: got %h required 0c3c3f0f0", {bus.req, bus.ctrlA, bus.ctrlB}); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if ({bus.req, bus.ctrlA, bus.ctrlB, bus.busy, bus.rsp_valid} !== 35'h0) begin errors++; $display("FAIL lo_async_clear: got %h required 0", {bus.req, bus.ctrlA, bus.ctrlB, bus.busy, bus.rsp_valid}); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL lo_async_ready: got %b required 1", bus.cmd_ready); end
        clear_mon();
        step();
        step();
        reset = 1'b1;
        repeat (10) step();
        checks++; if (rsp_n != 0 || up_q.size() != 0) begin errors++; $display("FAIL lo_abandon: got rsp %0d req %0d required 0 0", rsp_n, up_q.size()); end
        checks++; if ({bus.cmd_ready, bus.busy} !== 2'b10) begin errors++; $display("FAIL lo_fifo_empty: got %b required 10", {bus.cmd_ready, bus.busy}); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rsp_n  = 0;
        to_n   = 0;
        test_reset();
        test_single();
        test_timeout();
        test_fifo_full();
        test_push_pop_full1();
        test_reset_in_lo();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ats21_cmd_driver.md
Name: ats21_cmd_driver

Overview:
Host-side issuer for the ATS21 programmable clock/alarm block. It buffers pairs of 32-bit commands (client A, client B) from an upstream controller and runs the ATS21 req/ready handshake. It drives each command as two 16-bit halves on ctrlA/ctrlB, upper half first, then captures the statA/statB result. It sits between the system controller and the ATS21 instance and returns one response per command pair.

Parameters:
CMD_DEPTH, 4, command FIFO entries (power of 2, ≥2)
READY_TIMEOUT, 15, max cycles in REQ waiting for ready before abort
RESP_LAT, 2, cycles from last half-word driven to statA/statB sample

Ports:
clk  input  1  single design clock
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  upstream command pair valid
cmd_ready  output  1  FIFO can accept (not full)
cmd_a  input  32  client A instruction
cmd_b  input  32  client B instruction
req  output  1  request to ATS21
ready  input  1  ATS21 ready
ctrlA  output  16  half-word bus to ATS21 ctrlA
ctrlB  output  16  half-word bus to ATS21 ctrlB
statA  input  2  ATS21 client A status (00 Ack, 01 Error, 10 Nack)
statB  input  2  ATS21 client B status
rsp_valid  output  1  one-cycle response strobe
rsp_statA  output  2  captured client A status
rsp_statB  output  2  captured client B status
rsp_timeout  output  1  response was a ready-timeout abort
busy  output  1  FSM not in IDLE

Behaviour:
- All outputs registered. Reset (async, reset low) forces: req=0, ctrlA=ctrlB=0, rsp_valid=0, rsp_statA=rsp_statB=2'b10, rsp_timeout=0, busy=0, FIFO empty, cmd_ready=1, FSM=IDLE, counters 0. Reset mid-transaction abandons it with no response.
- FIFO: push {cmd_a,cmd_b} when cmd_valid&&cmd_ready. cmd_ready = !full, from the registered count. Push and pop in the same cycle leave the count unchanged. cmd_valid while full is ignored (no overwrite). Strict FIFO order.
- FSM states: IDLE, REQ, LO, WAIT.
- IDLE: if FIFO non-empty, pop the head into working regs. Next cycle: req=1, ctrlA=cmd_a[31:16], ctrlB=cmd_b[31:16], timeout counter=0, go REQ.
- REQ: hold req and the upper halves.
  - At an edge where ready==1 is sampled: req<=0, ctrlA<=cmd_a[15:0], ctrlB<=cmd_b[15:0], go LO.
  - Otherwise increment the counter. When the counter reaches READY_TIMEOUT-1 without ready: req<=0, ctrl<=0, rsp_valid<=1, rsp_timeout<=1, rsp_stat*<=10, go IDLE.
- Timing contract vs ATS21: upper half is valid on the edge after ATS21 raises ready; lower half is valid one edge later. Upper half must be on the bus while req is high.
- LO: lower halves held exactly one cycle, then ctrl<=0, latency counter=0, go WAIT.
- WAIT: count RESP_LAT cycles. On the last one, sample statA/statB into rsp_stat*, pulse rsp_valid for one cycle with rsp_timeout=0, go IDLE.
- rsp_valid is high for exactly 1 cycle per popped command. No backpressure on the response.
- Back-to-back commands: the earliest next req is 1 cycle after rsp_valid (IDLE pop cycle). Minimum turnaround = 1+k+1+RESP_LAT+1 cycles, where k is ready latency.
- ready sampled high outside REQ is ignored. A ready glitch in LO or WAIT has no effect.
- busy=1 in REQ, LO, WAIT.
- Counters saturate and never wrap. The FIFO pointers wrap modulo CMD_DEPTH.

Test Plan:
- Reset then single pair cmd_a=32'h2A40_1234, cmd_b=32'h4C80_0000, ready 1 cycle after req → ctrlA shows 2A40 then 1234 on consecutive cycles, ctrlB shows 4C80 then 0000. req drops on the ready edge. rsp_valid fires RESP_LAT+1 cycles after the lower half, with rsp_stat = statA/statB sampled (e.g. 00/01).
- ready never asserted → req high exactly 15 cycles, then rsp_valid=1, rsp_timeout=1, rsp_stat=10/10, busy=0 next cycle.
- Push 5 pairs with no pops (ready held low, first in REQ) → cmd_ready=0 after 4 entries occupy the FIFO. The 5th is accepted only after the first pop. Responses come out in push order.
- Simultaneous push and pop at full-1 → count unchanged, cmd_ready stays 1, no entry lost or duplicated.
- Assert reset low while in LO → req=0, ctrl=0, rsp_valid never pulses, FIFO empty, cmd_ready=1 immediately (async).
- ready asserted during WAIT and ready held high continuously → no extra half-words driven, exactly one response per command.
